// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the 8-source round-robin bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bus_arb_pkg;

  // Number of bus sources feeding the 8:1 mux and the width of its select.
  localparam int NUM_SRC = 8;
  localparam int SEL_W   = 3;

  // Hold counter width; wide enough for the largest legal MAX_HOLD (255).
  localparam int HOLD_W  = 8;

  // Arbiter FSM: IDLE has no owner, OWN has exactly one granted source.
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // One-hot decode of a source index, used for both gnt and exclusion masks.
  function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SEL_W-1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin search: first eligible source after 'last', wrapping 7 -> 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; 'found' low means no source is eligible.
module rr_picker
  import bus_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   last,
  input  logic [NUM_SRC-1:0] mask,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_SRC-1:0] elig;
  logic [SEL_W-1:0]   cand;

  // A masked source is never eligible; the owner is masked when it is being timed out.
  assign elig = req & ~mask;

  // Walk last+1 .. last+8 (mod 8); the 3-bit add provides the wrap for free.
  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = last + SEL_W'(k);
      if (!found && elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin 8:1 bus arbiter with registered one-hot grant and binary mux select.
// Latency: 1 cycle from req sampled at an edge to gnt/selectors/busy after that edge.
// Backpressure: owner holds until it drops req; optional watchdog BUS_ARB_TIMEOUT_EN caps hold at MAX_HOLD.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SEL_W-1:0]   selectors,
  output logic               busy,
  output logic               revoked
);

  // Reject out-of-range hold limits at elaboration time.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter: MAX_HOLD must lie in 2..255");
  end

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q,   sel_d;
  logic [SEL_W-1:0]   last_q,  last_d;
  logic [NUM_SRC-1:0] gnt_q,   gnt_d;
  logic               busy_q,  busy_d;

  logic               owner_req;
  logic               do_grant;
  logic [NUM_SRC-1:0] pick_mask;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;

`ifdef BUS_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               rev_q,  rev_d;
  logic               hold_expired;

  // The owner has used its last allowed cycle once the counter hits MAX_HOLD-1.
  assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD - 1));

  // Exclude the current owner only when it is about to be forcibly rotated out.
  assign pick_mask = (state_q == OWN && owner_req && hold_expired) ? src_onehot(sel_q) : '0;
`else
  assign pick_mask = '0;
`endif

  // In IDLE, sel_q still holds the previous owner, so this bit is simply ignored there.
  assign owner_req = req[sel_q];

  rr_picker u_rr_picker (
    .req   (req),
    .last  (last_q),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and next-output decode; every grant path funnels through do_grant.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
    do_grant = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d   = hold_q;
    rev_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          do_grant = 1'b1;
        end
      end
      OWN: begin
        if (!owner_req) begin
          // Release and handoff share the same edge, so there is no idle bubble.
          if (pick_found) begin
            do_grant = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (hold_expired) begin
          // Rotate to another requester if one exists; a lone owner keeps the bus.
          if (pick_found) begin
            do_grant = 1'b1;
            rev_d    = 1'b1;
          end else begin
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (do_grant) begin
      state_d = OWN;
      sel_d   = pick_idx;
      last_d  = pick_idx;
      gnt_d   = src_onehot(pick_idx);
      busy_d  = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
      hold_d  = '0;
`endif
    end
  end

  // Arbiter state and registered outputs; last resets to 7 so source 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_SRC - 1);
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  // Watchdog hold counter and the one-cycle revoke pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      rev_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rev_q  <= rev_d;
    end
  end

  assign revoked = rev_q;
`else
  assign revoked = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign selectors = sel_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized requests vs a reference model.
// Latency: model predicts outputs one edge after req is sampled.
// Backpressure: watchdog scenarios adapt to whether BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;

  localparam int MAXH = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] selectors;
  logic       busy;
  logic       revoked;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .selectors (selectors),
    .busy      (busy),
    .revoked   (revoked)
  );

  always #5 clk = ~clk;

  // Reference model: owner is -1 when nobody holds the bus.
  int m_owner = -1;
  int m_last  = 7;
  int m_sel   = 0;
  int m_hold  = 0;
  bit m_rev   = 1'b0;

  function automatic int rr_pick(input logic [7:0] r, input int last, input int excl);
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = (last + k) % 8;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each sampling edge (and on async reset).
  always @(posedge clk or negedge rst_n) begin
    int p;
    if (!rst_n) begin
      m_owner = -1; m_last = 7; m_sel = 0; m_hold = 0; m_rev = 1'b0;
    end else begin
      m_rev = 1'b0;
      p = -1;
      if (m_owner < 0 || !req[m_owner]) begin
        p = rr_pick(req, m_last, -1);
        if (p < 0) m_owner = -1;
      end else if (TO_EN && m_hold == MAXH - 1) begin
        p = rr_pick(req, m_last, m_owner);
        if (p >= 0) m_rev = 1'b1;
        else m_hold = 0;
      end else begin
        m_hold++;
      end
      if (p >= 0) begin
        m_owner = p; m_last = p; m_sel = p; m_hold = 0;
      end
    end
  end

  // Every-cycle comparison against the model plus the grant/select invariants.
  always @(negedge clk) begin
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    chk("gnt", gnt, eg);
    chk("selectors", selectors, m_sel);
    chk("busy", busy, m_owner >= 0);
    chk("revoked", revoked, m_rev);
    chk("gnt_onehot0", $countones(gnt) <= 1, 1);
    chk("gnt_vs_sel", gnt, busy ? (8'h01 << selectors) : 8'h00);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    #3;
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_sel", selectors, 3'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_revoked", revoked, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Single request then release; selectors keeps last owner in IDLE.
    req = 8'h01;
    step();
    chk("single_gnt", gnt, 8'h01);
    chk("single_sel", selectors, 3'd0);
    chk("single_busy", busy, 1'b1);
    req = 8'h00;
    step();
    chk("release_gnt", gnt, 8'h00);
    chk("release_busy", busy, 1'b0);
    chk("release_sel", selectors, 3'd0);

    // All requesting, each owner drops for one cycle: 0,1,...,7,0 back to back.
    do_reset();
    req = 8'hFF;
    step();
    for (int k = 0; k <= 8; k++) begin
      chk("rr_sel", selectors, k % 8);
      chk("rr_busy", busy, 1'b1);
      req = 8'hFF & ~(8'h01 << (k % 8));
      step();
    end
    req = 8'h00;
    step();

    // No preemption of owner 5; direct handoff to 2 on release.
    do_reset();
    req = 8'h20;
    step();
    chk("own5_gnt", gnt, 8'h20);
    req = 8'h24;
    step();
    chk("nopreempt_gnt1", gnt, 8'h20);
    step();
    chk("nopreempt_gnt2", gnt, 8'h20);
    req = 8'h04;
    step();
    chk("handoff_gnt", gnt, 8'h04);
    chk("handoff_sel", selectors, 3'd2);

    // Watchdog behaviour (or its absence).
    do_reset();
    req = 8'h09;
    if (TO_EN) begin
      for (int i = 0; i < MAXH; i++) begin
        step();
        chk("to_hold0_gnt", gnt, 8'h01);
        chk("to_hold0_rev", revoked, 1'b0);
      end
      step();
      chk("to_revoke_gnt", gnt, 8'h08);
      chk("to_revoke_pulse", revoked, 1'b1);
      step();
      chk("to_after_rev", revoked, 1'b0);
      chk("to_after_gnt", gnt, 8'h08);
      req = 8'h01;
      step();
      chk("to_back0_gnt", gnt, 8'h01);
      for (int i = 0; i < 2 * MAXH; i++) begin
        step();
        chk("to_alone_gnt", gnt, 8'h01);
        chk("to_alone_rev", revoked, 1'b0);
      end
    end else begin
      for (int i = 0; i < 3 * MAXH; i++) begin
        step();
        chk("nto_hold_gnt", gnt, 8'h01);
        chk("nto_hold_rev", revoked, 1'b0);
      end
    end

    // Asynchronous reset while owner 6 holds.
    do_reset();
    req = 8'h40;
    step();
    chk("own6_gnt", gnt, 8'h40);
    chk("own6_sel", selectors, 3'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 8'h00);
    chk("arst_sel", selectors, 3'd0);
    chk("arst_busy", busy, 1'b0);
    step();
    chk("arst_hold_gnt", gnt, 8'h00);
    rst_n = 1'b1;
    step();
    chk("arst_regrant_gnt", gnt, 8'h40);
    chk("arst_regrant_sel", selectors, 3'd6);

    // Randomized requests with occasional mid-cycle async reset.
    req = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) req = req ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) req = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst_n = 1'b0;
      end
    end
    rst_n = 1'b1;
    req   = 8'h00;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, maximum consecutive cycles one owner may hold the bus (range 2..255).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port req  input  8  request from bus source i (i = 0..7, matching the 8:1 bus mux inputs in0..in7); level-sensitive, held high while bus is wanted.
REQ-005 Port gnt  output  8  one-hot grant; at most one bit set.
REQ-006 Port selectors  output  3  binary index of current owner; drives the bus mux select input.
REQ-007 Port busy  output  1  high while any grant is active.
REQ-008 Port revoked  output  1  one-cycle pulse when the timeout watchdog forcibly removes an owner.

Function
REQ-009 The FSM SHALL have exactly two states: IDLE (no owner) and OWN (one owner granted).
REQ-010 All outputs SHALL be registered; a request sampled at rising edge N SHALL produce gnt/selectors/busy valid after edge N (1-cycle latency).
REQ-011 Arbitration SHALL be round-robin: search starts at (last + 1) mod 8, wraps past 7 to 0, and picks the first index with req high.
REQ-012 last SHALL update to the new owner index on every grant, including re-grants.
REQ-013 IDLE with req == 0: SHALL remain in IDLE, gnt = 0, busy = 0.
REQ-014 IDLE with any req bit high: SHALL grant the winner and enter OWN.
REQ-015 OWN with req[owner] high and no timeout: gnt and selectors SHALL hold unchanged; other requests SHALL NOT preempt.
REQ-016 OWN with req[owner] low: the owner is released in that same edge; if another requester is pending, it SHALL be granted directly (no idle bubble), otherwise go to IDLE with gnt = 0.
REQ-017 Owner release and a new request arriving in the same cycle SHALL be treated as back-to-back handoff per REQ-016.
REQ-018 In IDLE, selectors SHALL retain the last owner index; busy = 0 marks the bus value as don't-care.
REQ-019 gnt SHALL always equal the one-hot decode of selectors whenever busy = 1.
REQ-020 revoked SHALL be 0 in every cycle except the one defined in REQ-025.

Reset
REQ-021 While rst_n = 0, regardless of clock: state = IDLE, gnt = 8'b0, selectors = 3'b000, busy = 0, revoked = 0, hold counter = 0, last = 7 (requester 0 has first priority after reset).
REQ-022 Reset asserted mid-grant SHALL drop gnt immediately; no grant is issued until the first rising edge after rst_n deasserts.

Configuration
REQ-023 Macro BUS_ARB_TIMEOUT_EN SHALL compile the hold watchdog in or out.
REQ-024 With BUS_ARB_TIMEOUT_EN defined, a hold counter SHALL clear on every grant and increment each cycle in OWN.
REQ-025 With BUS_ARB_TIMEOUT_EN defined, when the counter reaches MAX_HOLD - 1 with req[owner] still high, the arbiter SHALL grant the next round-robin requester excluding the owner and pulse revoked for one cycle; if no other requester exists, the owner SHALL be kept, the counter cleared, and revoked SHALL stay 0.
REQ-026 Without BUS_ARB_TIMEOUT_EN, there SHALL be no counter logic, revoked SHALL be tied to 0, and ownership SHALL be unbounded.

Structure
REQ-027 Shared package bus_arb_pkg SHALL hold the state enum (IDLE, OWN), NUM_SRC = 8, and SEL_W = 3.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_picker with inputs req, last and mask, and outputs found and idx.

Verification
REQ-029 Reset, then req = 8'h01 -> one edge later gnt = 8'h01, selectors = 0, busy = 1; req = 0 -> next edge gnt = 0, busy = 0, selectors stays 0.
REQ-030 req = 8'hFF held; each owner drops and re-raises req for one cycle -> grants in order 0,1,...,7,0 with no idle cycle between.
REQ-031 Owner 5 holds, req[2] rises -> no preemption; req[5] drops -> same edge gnt = 8'h04, selectors = 2.
REQ-032 BUS_ARB_TIMEOUT_EN defined, MAX_HOLD = 4, req = 8'h09 held -> owner 0 for 4 cycles, then revoked pulse, owner 3; req = 8'h01 alone -> owner 0 kept, revoked = 0.
REQ-033 rst_n pulled low asynchronously while owner = 6 -> gnt = 0 and selectors = 0 immediately; after release with req = 8'h40 -> gnt = 8'h40 one edge later.
REQ-034 Every cycle: assert gnt is one-hot or zero, and gnt == (busy ? 1 << selectors : 0).
